// File: rtl/alu32_rr_sched8_pkg.sv
// Shared definitions for the alu32_rr_sched8 scheduler slice.
// Contents: FSM state encoding, requester count and select width,
// and an index-to-one-hot helper used by the picker and the scheduler.
package alu32_rr_sched8_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

    // Expand a requester index into its one-hot vector.
    function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] one_s;
        one_s = {{(N_REQ-1){1'b0}}, 1'b1};
        return one_s << idx;
    endfunction

endpackage

// File: rtl/alu32_rr_sched8_rr_pick8.sv
// rr_pick8: combinational round-robin picker.
// Ports:
//   req    [7:0] request vector
//   ptr    [2:0] highest-priority index for this pick
//   any          at least one request is set
//   idx    [2:0] first set bit found scanning ptr, ptr+1, ... mod 8
//   onehot [7:0] one-hot form of idx, zero when any=0
module rr_pick8
    import alu32_rr_sched8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic             any,
    output logic [SEL_W-1:0] idx,
    output logic [N_REQ-1:0] onehot
);

    logic [SEL_W-1:0] cand_s;

    // Scan offsets from farthest to nearest so the nearest set bit to ptr is the last write.
    always_comb begin
        any    = |req;
        idx    = {SEL_W{1'b0}};
        cand_s = {SEL_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_s = ptr + SEL_W'(i);
            if (req[cand_s]) begin
                idx = cand_s;
            end else begin
                idx = idx;
            end
        end
        if (any) begin
            onehot = idx_to_onehot(idx);
        end else begin
            onehot = {N_REQ{1'b0}};
        end
    end

endmodule

// File: rtl/alu32_rr_sched8.sv
// alu32_rr_sched8: round-robin scheduler sharing one multi-cycle ALU among 8 requesters.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   req        [7:0]    request levels, held until own resp_valid
//   gnt        [7:0]    one-hot grant, held ISSUE..RESP
//   sel        [2:0]    operand-mux select (granted index)
//   alu_start           one-cycle ALU launch pulse
//   alu_done            ALU completion strobe (only honoured in WAIT)
//   alu_result [DW-1:0] ALU result, valid with alu_done
//   resp_valid [7:0]    one-hot one-cycle response strobe
//   resp_data  [DW-1:0] captured result (0 on timeout), held until next response
//   resp_err            set with resp_valid when the ALU timed out
//   busy                high whenever the FSM is not IDLE
module alu32_rr_sched8
    import alu32_rr_sched8_pkg::*;
#(
    parameter int DW      = 32,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       req,
    output logic [7:0]       gnt,
    output logic [2:0]       sel,
    output logic             alu_start,
    input  logic             alu_done,
    input  logic [DW-1:0]    alu_result,
    output logic [7:0]       resp_valid,
    output logic [DW-1:0]    resp_data,
    output logic             resp_err,
    output logic             busy
);

    sched_state_t      state_r;
    logic [SEL_W-1:0]  ptr_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [N_REQ-1:0]  gnt_r;
    logic [SEL_W-1:0]  sel_r;
    logic              alu_start_r;
    logic [N_REQ-1:0]  resp_valid_r;
    logic [DW-1:0]     resp_data_r;
    logic              resp_err_r;
    logic              busy_r;

    logic              pick_any_s;
    logic [SEL_W-1:0]  pick_idx_s;
    logic [N_REQ-1:0]  pick_onehot_s;

    rr_pick8 u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .any    (pick_any_s),
        .idx    (pick_idx_s),
        .onehot (pick_onehot_s)
    );

    // Scheduler FSM; every output is a register written here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            ptr_r        <= {SEL_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            gnt_r        <= {N_REQ{1'b0}};
            sel_r        <= {SEL_W{1'b0}};
            alu_start_r  <= 1'b0;
            resp_valid_r <= {N_REQ{1'b0}};
            resp_data_r  <= {DW{1'b0}};
            resp_err_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (pick_any_s) begin
                        gnt_r       <= pick_onehot_s;
                        sel_r       <= pick_idx_s;
                        alu_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= S_ISSUE;
                    end else begin
                        state_r     <= S_IDLE;
                    end
                end
                S_ISSUE: begin
                    alu_start_r <= 1'b0;
                    cnt_r       <= {CNT_W{1'b0}};
                    state_r     <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    // A done on the terminal-count cycle is checked first, so it wins.
                    if (alu_done) begin
                        resp_data_r  <= alu_result;
                        resp_err_r   <= 1'b0;
                        resp_valid_r <= idx_to_onehot(sel_r);
                        state_r      <= S_RESP;
                    end else if (cnt_r == CNT_W'(TIMEOUT - 1)) begin
                        resp_data_r  <= {DW{1'b0}};
                        resp_err_r   <= 1'b1;
                        resp_valid_r <= idx_to_onehot(sel_r);
                        state_r      <= S_RESP;
                    end else begin
                        state_r      <= S_WAIT;
                    end
                end
                S_RESP: begin
                    resp_valid_r <= {N_REQ{1'b0}};
                    ptr_r        <= sel_r + {{(SEL_W-1){1'b0}}, 1'b1};
                    gnt_r        <= {N_REQ{1'b0}};
                    sel_r        <= {SEL_W{1'b0}};
                    busy_r       <= 1'b0;
                    state_r      <= S_IDLE;
                end
                default: begin
                    state_r      <= S_IDLE;
                    gnt_r        <= {N_REQ{1'b0}};
                    sel_r        <= {SEL_W{1'b0}};
                    alu_start_r  <= 1'b0;
                    resp_valid_r <= {N_REQ{1'b0}};
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = gnt_r;
    assign sel        = sel_r;
    assign alu_start  = alu_start_r;
    assign resp_valid = resp_valid_r;
    assign resp_data  = resp_data_r;
    assign resp_err   = resp_err_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_alu32_rr_sched8.sv
// Scoreboard bench for alu32_rr_sched8 (TIMEOUT=8). Stimulus tasks push the
// expected grant and response; a monitor pops and compares at every alu_start
// and every resp_valid, and also checks start-to-response latency.
module tb_alu32_rr_sched8;

    localparam int TMO = 8;

    typedef struct packed {
        logic [7:0] oh;
        logic [2:0] idx;
    } gexp_t;

    typedef struct packed {
        logic [7:0]  oh;
        logic [31:0] data;
        logic        err;
        logic [7:0]  lat;
    } rexp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  req = 8'h00;
    logic [7:0]  gnt;
    logic [2:0]  sel;
    logic        alu_start;
    logic        alu_done_m = 1'b0;
    logic        stray_done = 1'b0;
    logic [31:0] alu_result = 32'hA5A5A5A5;
    logic [7:0]  resp_valid;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          alu_delay = -1;
    logic [31:0] alu_res = 32'h0;
    gexp_t       gq[$];
    rexp_t       rq[$];

    alu32_rr_sched8 #(.DW(32), .TIMEOUT(TMO), .CNT_W(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .sel        (sel),
        .alu_start  (alu_start),
        .alu_done   (alu_done_m | stray_done),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ALU model: raise alu_done for one cycle, alu_delay cycles after the start cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (alu_start && alu_delay > 0) begin
                repeat (alu_delay) @(negedge clk);
                alu_done_m = 1'b1;
                alu_result = alu_res;
                @(negedge clk);
                alu_done_m = 1'b0;
                alu_result = 32'hA5A5A5A5;
            end
        end
    end

    // Monitor: compare grants on alu_start and responses on resp_valid.
    initial begin
        gexp_t g;
        rexp_t r;
        forever begin
            @(negedge clk);
            cyc++;
            if (alu_start) begin
                chk("start_expected", 64'(gq.size() != 0), 64'd1);
                if (gq.size() != 0) begin
                    g = gq.pop_front();
                    chk("gnt", 64'(gnt), 64'(g.oh));
                    chk("sel", 64'(sel), 64'(g.idx));
                    chk("busy_issue", 64'(busy), 64'd1);
                end
                start_cyc = cyc;
            end
            if (resp_valid != 8'h00) begin
                chk("resp_expected", 64'(rq.size() != 0), 64'd1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    chk("resp_valid", 64'(resp_valid), 64'(r.oh));
                    chk("resp_data", 64'(resp_data), 64'(r.data));
                    chk("resp_err", 64'(resp_err), 64'(r.err));
                    chk("resp_latency", 64'(cyc - start_cyc), 64'(r.lat));
                    chk("gnt_held_resp", 64'(gnt), 64'(r.oh));
                end
            end
        end
    end

    // One transaction: d = cycles from start to alu_done, d<=0 means never.
    task automatic txn(input logic [7:0] r, input logic [2:0] idx, input int d,
                       input logic [31:0] res, input bit drop);
        logic [7:0] one8;
        gexp_t g;
        rexp_t e;
        int n;
        one8 = 8'h01;
        g.oh = one8 << idx;
        g.idx = idx;
        e.oh = one8 << idx;
        if (d > 0 && d <= TMO) begin
            e.data = res;
            e.err = 1'b0;
            e.lat = 8'(d + 1);
        end else begin
            e.data = 32'h0;
            e.err = 1'b1;
            e.lat = 8'(TMO + 1);
        end
        alu_delay = d;
        alu_res = res;
        gq.push_back(g);
        rq.push_back(e);
        req = r;
        n = 0;
        do begin @(negedge clk); n++; end while (!alu_start && n < 50);
        chk("start_seen", 64'(alu_start), 64'd1);
        if (drop) req = 8'h00;
        n = 0;
        do begin @(negedge clk); n++; end while (resp_valid == 8'h00 && n < 60);
        chk("resp_seen", 64'(resp_valid != 8'h00), 64'd1);
        req = 8'h00;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_gnt"}, 64'(gnt), 64'd0);
        chk({tag, "_sel"}, 64'(sel), 64'd0);
        chk({tag, "_start"}, 64'(alu_start), 64'd0);
        chk({tag, "_rv"}, 64'(resp_valid), 64'd0);
        chk({tag, "_rdata"}, 64'(resp_data), 64'd0);
        chk({tag, "_rerr"}, 64'(resp_err), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic apply_reset();
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] ix;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_zero("reset");

        // Single requester, ALU done 3 cycles after start.
        txn(8'h01, 3'd0, 3, 32'hDEADBEEF, 1'b0);

        // All requesters held: order 0..7,0 from a fresh pointer.
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            ix = 3'(i);
            txn(8'hFF, ix, 2, 32'h1000_0000 + 32'(i), 1'b0);
        end

        // ptr=1 now: serve 2, then 8'h09 picks 3, then 0.
        txn(8'h04, 3'd2, 1, 32'h0000_0022, 1'b0);
        txn(8'h09, 3'd3, 1, 32'h0000_0033, 1'b0);
        txn(8'h09, 3'd0, 1, 32'h0000_0011, 1'b0);

        // Timeout, then done exactly on the terminal-count cycle.
        txn(8'h02, 3'd1, -1, 32'h0, 1'b0);
        chk("hold_err", 64'(resp_err), 64'd1);
        txn(8'h04, 3'd2, TMO, 32'hCAFEF00D, 1'b0);

        // Requester drops req after grant; response still delivered.
        txn(8'h10, 3'd4, 4, 32'h12345678, 1'b0);
        txn(8'h20, 3'd5, 2, 32'h87654321, 1'b1);
        chk("hold_data", 64'(resp_data), 64'h87654321);

        // Reset during WAIT: asynchronous clear, no response.
        begin
            gexp_t g;
            int n;
            g.oh = 8'h40;
            g.idx = 3'd6;
            gq.push_back(g);
            alu_delay = -1;
            req = 8'h40;
            n = 0;
            do begin @(negedge clk); n++; end while (!alu_start && n < 50);
            chk("rst_start_seen", 64'(alu_start), 64'd1);
            repeat (3) @(negedge clk);
            chk("wait_busy", 64'(busy), 64'd1);
            #2 rst_n = 1'b0;
            #1 check_zero("async_rst");
            req = 8'h00;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (3) @(negedge clk);
        end

        // Stray alu_done in IDLE is ignored.
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy", 64'(busy), 64'd0);

        // Pointer restarted at 0: 8'h81 picks 0, then 7.
        txn(8'h81, 3'd0, 1, 32'h0000_0A0A, 1'b0);
        txn(8'h80, 3'd7, 5, 32'h7777_7777, 1'b0);

        repeat (5) @(negedge clk);
        chk("gq_empty", 64'(gq.size()), 64'd0);
        chk("rq_empty", 64'(rq.size()), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
